neuron_accumulator: RTL and testbench
=====================================

Name: neuron_accumulator

Overview:
- Downstream consumer of the 10-lane DotProduct stage.
- Sums a fixed number of signed Q8.18 partial dot products per neuron and adds a per-neuron bias.
- Applies ReLU with saturation, emits one activation per neuron, and tracks the argmax across neurons to produce a class decision per image.
- No backpressure: accepts one partial per cycle, back-to-back.

Parameters:
- CHUNKS_PER_NEURON, 79, number of 10-element partial products summed per neuron (784 pixels padded to 790).
- NUM_NEURONS, 10, neurons per image; also the class count.
- IN_W, 26, width of the partial product and bias, signed Q8.18.
- IDX_W, 4, width of the neuron/class index (ceil(log2(NUM_NEURONS))).

Ports:
- clk  input  1  rising-edge clock.
- GlobalReset  input  1  asynchronous reset, active-low.
- clr  input  1  synchronous abort of the current image; clears counters and argmax.
- in_valid  input  1  in_value is a valid partial product this cycle.
- in_value  input  IN_W  signed Q8.18 partial from DotProduct.value.
- in_bias  input  IN_W  signed Q8.18 bias; sampled only with chunk 0 of each neuron.
- out_valid  output  1  one-cycle pulse: neuron activation valid.
- out_value  output  IN_W  activation, Q8.18, always >= 0.
- out_index  output  IDX_W  neuron index of out_value.
- out_sat  output  1  out_value was clipped to max positive.
- class_valid  output  1  one-cycle pulse: image decision valid.
- class_id  output  IDX_W  argmax neuron index.
- class_score  output  IN_W  winning activation.

Behaviour:
- Reset (GlobalReset=0, async): all outputs 0, chunk_cnt=0, neuron_cnt=0, acc=0, best_score=0, best_id=0, state=ACCUM.
- Accumulator width: ACC_W = IN_W + clog2(CHUNKS_PER_NEURON) + 1. All operands are sign-extended; there is no internal overflow.
- Accepted chunk (in_valid=1, clr=0):
  - chunk_cnt==0: acc <= sext(in_bias) + sext(in_value).
  - otherwise: acc <= acc + sext(in_value).
  - chunk_cnt increments and wraps to 0 after CHUNKS_PER_NEURON-1.
- Final chunk (chunk_cnt==CHUNKS_PER_NEURON-1): at that edge, sum = acc + sext(in_value) (or bias + value if CHUNKS_PER_NEURON==1), and the following are registered:
  - out_value = 0 if sum<0; 2^(IN_W-1)-1 if sum > that value; else sum[IN_W-1:0].
  - out_sat = 1 only in the clip case.
  - out_index = neuron_cnt; out_valid=1 for exactly the next cycle.
  - Latency: 1 cycle from the last chunk to out_valid.
- Argmax: updated on the same edge. best is replaced only if the activation is strictly greater than best_score, or if neuron_cnt==0. Ties keep the lower index.
- State machine:
  - ACCUM: normal accumulation.
  - ACCUM -> CLASSIFY: on the final chunk of neuron NUM_NEURONS-1.
  - CLASSIFY: one cycle; class_valid=1, class_id/class_score = final best. This is the cycle after the last out_valid, i.e. 2 cycles after the last chunk.
  - CLASSIFY -> ACCUM: unconditional. neuron_cnt wraps to 0 on the entering edge.
  - in_valid during CLASSIFY is accepted as chunk 0 of the next image; there are no bubbles.
- Outputs hold their last values between pulses; only out_valid and class_valid are pulses.
- in_valid=0 cycles stall the counters; acc is held.
- clr=1:
  - Next edge: chunk_cnt, neuron_cnt, acc, best cleared; state=ACCUM; out_valid=class_valid=0.
  - clr has priority over a simultaneous in_valid, whose chunk is dropped.
  - An out_valid/class_valid already registered in the current cycle is not retracted.
- GlobalReset asserted mid-image: immediate clear as above; no pulse is produced for the partial image.

Decomposition:
- Shared package holds:
  - the Q8.18 format constants: FRAC_BITS=18, ONE=262144, Q_MAX=2^25-1;
  - the defaults for CHUNKS_PER_NEURON and NUM_NEURONS;
  - the state enumeration ACCUM/CLASSIFY.
- One sub-module is natural: relu_sat. It is purely combinational (ACC_W sum -> IN_W activation + sat flag) and is reused by later layers.

Test Plan:
- GlobalReset low for 3 cycles mid-neuron (chunk_cnt=2), then high -> all outputs 0; next in_valid is treated as chunk 0 of neuron 0 and uses in_bias.
- CHUNKS=3, NUM=2; neuron 0 chunks 0x40000, 0x80000, 0xC0000, bias 0x20000 -> one cycle after 3rd chunk: out_valid=1, out_value=0x1A0000 (6.5), out_index=0, out_sat=0.
- CHUNKS=3; chunks -1.0 (0x3FC0000) x3, bias 0 -> out_value=0, out_sat=0 (ReLU).
- CHUNKS=3; chunks 0x1FFFFFF x3, bias 0x1FFFFFF -> out_value=0x1FFFFFF, out_sat=1.
- CHUNKS=1, NUM=3, back-to-back activations 2.0, 5.0, 5.0 -> class_valid 2 cycles after last chunk with class_id=1, class_score=0x140000. The next image's chunk in the CLASSIFY cycle is accepted as neuron 0.
- CHUNKS=3; clr=1 with in_valid=1 after 2 chunks of neuron 1 -> that chunk is dropped, no out_valid; the next 3 chunks produce out_index=0.

Source files
------------

// File: rtl/neuron_accumulator_pkg.sv
// Shared constants and types for the neuron accumulator and later layers.
// Activations and partials are signed Q8.18 fixed point.
package neuron_accumulator_pkg;

  localparam int FRAC_BITS = 18;
  localparam int ONE       = 262144;
  localparam int Q_MAX     = (1 << 25) - 1;

  localparam int DEF_CHUNKS_PER_NEURON = 79;
  localparam int DEF_NUM_NEURONS       = 10;

  typedef enum logic {
    ACCUM    = 1'b0,
    CLASSIFY = 1'b1
  } state_t;

endpackage

// File: rtl/relu_sat.sv
// ReLU with saturation: wide signed sum in, non-negative IN_W activation out.
// Purely combinational so later layers can reuse it.
module relu_sat
  import neuron_accumulator_pkg::*;
#(
  parameter int ACC_W = 34,
  parameter int IN_W  = 26
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic        [IN_W-1:0]  act,
  output logic                    sat
);

  // Any set bit between the sign and the top activation bit means the value exceeds Q_MAX.
  always_comb begin
    act = '0;
    sat = 1'b0;
    if (sum[ACC_W-1]) begin
      act = '0;
    end else if (|sum[ACC_W-2:IN_W-1]) begin
      act = {1'b0, {(IN_W-1){1'b1}}};
      sat = 1'b1;
    end else begin
      act = sum[IN_W-1:0];
    end
  end

endmodule

// File: rtl/neuron_accumulator.sv
// Sums per-neuron partial dot products plus bias, applies ReLU/saturation,
// and tracks the argmax across neurons to emit one class decision per image.
module neuron_accumulator
  import neuron_accumulator_pkg::*;
#(
  parameter int CHUNKS_PER_NEURON = DEF_CHUNKS_PER_NEURON,
  parameter int NUM_NEURONS       = DEF_NUM_NEURONS,
  parameter int IN_W              = 26,
  parameter int IDX_W             = 4
) (
  input  logic                   clk,
  input  logic                   GlobalReset,
  input  logic                   clr,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] in_value,
  input  logic signed [IN_W-1:0] in_bias,
  output logic                   out_valid,
  output logic        [IN_W-1:0] out_value,
  output logic       [IDX_W-1:0] out_index,
  output logic                   out_sat,
  output logic                   class_valid,
  output logic       [IDX_W-1:0] class_id,
  output logic        [IN_W-1:0] class_score
);

  localparam int ACC_W = IN_W + $clog2(CHUNKS_PER_NEURON) + 1;
  localparam int CNT_W = (CHUNKS_PER_NEURON > 1) ? $clog2(CHUNKS_PER_NEURON) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK  = CNT_W'(CHUNKS_PER_NEURON - 1);
  localparam logic [IDX_W-1:0] LAST_NEURON = IDX_W'(NUM_NEURONS - 1);

  state_t state, state_nxt;

  logic        [CNT_W-1:0] chunk_cnt;
  logic        [IDX_W-1:0] neuron_cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] val_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] sum;
  logic        [IN_W-1:0]  act;
  logic        [IN_W-1:0]  best_score;
  logic        [IDX_W-1:0] best_id;
  logic                    sat;
  logic                    accept;
  logic                    last_chunk;
  logic                    last_neuron;
  logic                    image_done;
  logic                    take_best;

  assign val_ext     = {{(ACC_W-IN_W){in_value[IN_W-1]}}, in_value};
  assign bias_ext    = {{(ACC_W-IN_W){in_bias[IN_W-1]}}, in_bias};
  assign accept      = in_valid && !clr;
  assign last_chunk  = (chunk_cnt == LAST_CHUNK);
  assign last_neuron = (neuron_cnt == LAST_NEURON);
  assign image_done  = accept && last_chunk && last_neuron;
  assign base        = (chunk_cnt == '0) ? bias_ext : acc;
  assign sum         = base + val_ext;
  // Neuron 0 always seeds the argmax; ties keep the earlier (lower) index.
  assign take_best   = (neuron_cnt == '0) || (act > best_score);

  relu_sat #(
    .ACC_W(ACC_W),
    .IN_W (IN_W)
  ) u_relu_sat (
    .sum(sum),
    .act(act),
    .sat(sat)
  );

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) state <= ACCUM;
    else              state <= state_nxt;
  end

  // CLASSIFY only repeats when a single-chunk, single-neuron image completes inside it.
  always_comb begin
    state_nxt = ACCUM;
    case (state)
      ACCUM:    if (image_done) state_nxt = CLASSIFY;
      CLASSIFY: if (image_done) state_nxt = CLASSIFY;
      default:  state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      chunk_cnt   <= '0;
      neuron_cnt  <= '0;
      acc         <= '0;
      best_score  <= '0;
      best_id     <= '0;
      out_valid   <= 1'b0;
      out_value   <= '0;
      out_index   <= '0;
      out_sat     <= 1'b0;
      class_valid <= 1'b0;
      class_id    <= '0;
      class_score <= '0;
    end else begin
      out_valid   <= 1'b0;
      class_valid <= 1'b0;
      if (clr) begin
        chunk_cnt  <= '0;
        neuron_cnt <= '0;
        acc        <= '0;
        best_score <= '0;
        best_id    <= '0;
      end else begin
        if (state == CLASSIFY) begin
          class_valid <= 1'b1;
          class_id    <= best_id;
          class_score <= best_score;
        end
        if (accept) begin
          acc       <= sum;
          chunk_cnt <= last_chunk ? '0 : chunk_cnt + 1'b1;
          if (last_chunk) begin
            out_valid  <= 1'b1;
            out_value  <= act;
            out_sat    <= sat;
            out_index  <= neuron_cnt;
            neuron_cnt <= last_neuron ? '0 : neuron_cnt + 1'b1;
            if (take_best) begin
              best_id    <= neuron_cnt;
              best_score <= act;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed test of neuron_accumulator with two small configurations:
// instance a (3 chunks, 2 neurons) and instance b (1 chunk, 3 neurons).
module tb_neuron_accumulator;

  localparam int IN_W  = 26;
  localparam int IDX_W = 4;

  logic clk = 1'b0;
  logic rst_n;

  logic             clr_a, in_valid_a, clr_b, in_valid_b;
  logic [IN_W-1:0]  in_value_a, in_bias_a, in_value_b, in_bias_b;
  logic             out_valid_a, out_sat_a, class_valid_a;
  logic             out_valid_b, out_sat_b, class_valid_b;
  logic [IN_W-1:0]  out_value_a, class_score_a, out_value_b, class_score_b;
  logic [IDX_W-1:0] out_index_a, class_id_a, out_index_b, class_id_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  neuron_accumulator #(
    .CHUNKS_PER_NEURON(3), .NUM_NEURONS(2), .IN_W(IN_W), .IDX_W(IDX_W)
  ) dut_a (
    .clk(clk), .GlobalReset(rst_n), .clr(clr_a),
    .in_valid(in_valid_a), .in_value(in_value_a), .in_bias(in_bias_a),
    .out_valid(out_valid_a), .out_value(out_value_a), .out_index(out_index_a),
    .out_sat(out_sat_a), .class_valid(class_valid_a), .class_id(class_id_a),
    .class_score(class_score_a)
  );

  neuron_accumulator #(
    .CHUNKS_PER_NEURON(1), .NUM_NEURONS(3), .IN_W(IN_W), .IDX_W(IDX_W)
  ) dut_b (
    .clk(clk), .GlobalReset(rst_n), .clr(clr_b),
    .in_valid(in_valid_b), .in_value(in_value_b), .in_bias(in_bias_b),
    .out_valid(out_valid_b), .out_value(out_value_b), .out_index(out_index_b),
    .out_sat(out_sat_b), .class_valid(class_valid_b), .class_id(class_id_b),
    .class_score(class_score_b)
  );

  // Drive one cycle on the selected instance at a negedge; return at the next negedge.
  task automatic applyStimulus(input bit sel_b, input logic v, input logic [IN_W-1:0] val,
                               input logic [IN_W-1:0] bias, input logic c);
    in_valid_a = 1'b0; clr_a = 1'b0; in_valid_b = 1'b0; clr_b = 1'b0;
    if (sel_b) begin
      in_valid_b = v; in_value_b = val; in_bias_b = bias; clr_b = c;
    end else begin
      in_valid_a = v; in_value_a = val; in_bias_a = bias; clr_a = c;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid_a = 1'b0; clr_a = 1'b0; in_valid_b = 1'b0; clr_b = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clr_a = 0; in_valid_a = 0; in_value_a = '0; in_bias_a = '0;
    clr_b = 0; in_valid_b = 0; in_value_b = '0; in_bias_b = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst out_valid_a", out_valid_a, 0);
    checkOutput("rst out_value_a", out_value_a, 0);
    checkOutput("rst out_index_a", out_index_a, 0);
    checkOutput("rst out_sat_a", out_sat_a, 0);
    checkOutput("rst class_valid_a", class_valid_a, 0);
    checkOutput("rst class_id_a", class_id_a, 0);
    checkOutput("rst class_score_a", class_score_a, 0);
    checkOutput("rst out_valid_b", out_valid_b, 0);
    checkOutput("rst class_valid_b", class_valid_b, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // a, image 1, neuron 0: 0.5 + 1.0 + 2.0 + 3.0 = 6.5
    applyStimulus(0, 1, 26'h0040000, 26'h0020000, 0);
    applyStimulus(0, 1, 26'h0080000, 26'h3FFFFFF, 0);
    checkOutput("n0 early out_valid", out_valid_a, 0);
    applyStimulus(0, 1, 26'h00C0000, 26'h3FFFFFF, 0);
    checkOutput("n0 out_valid", out_valid_a, 1);
    checkOutput("n0 out_value", out_value_a, 32'h1A0000);
    checkOutput("n0 out_index", out_index_a, 0);
    checkOutput("n0 out_sat", out_sat_a, 0);
    applyStimulus(0, 0, '0, '0, 0);
    checkOutput("n0 pulse end", out_valid_a, 0);
    checkOutput("n0 value hold", out_value_a, 32'h1A0000);

    // a, neuron 1: three times -1.0 -> ReLU clamps to 0
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 26'h3FC0000, 26'h0000000, 0);
    checkOutput("relu out_valid", out_valid_a, 1);
    checkOutput("relu out_value", out_value_a, 0);
    checkOutput("relu out_sat", out_sat_a, 0);
    checkOutput("relu out_index", out_index_a, 1);
    checkOutput("a class early", class_valid_a, 0);
    applyStimulus(0, 0, '0, '0, 0);
    checkOutput("a class_valid", class_valid_a, 1);
    checkOutput("a class_id", class_id_a, 0);
    checkOutput("a class_score", class_score_a, 32'h1A0000);
    checkOutput("a out_valid after", out_valid_a, 0);
    applyStimulus(0, 0, '0, '0, 0);
    checkOutput("a class pulse end", class_valid_a, 0);

    // a, image 2, neuron 0: saturating sum
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 26'h1FFFFFF, 26'h1FFFFFF, 0);
    checkOutput("sat out_valid", out_valid_a, 1);
    checkOutput("sat out_value", out_value_a, 32'h1FFFFFF);
    checkOutput("sat out_sat", out_sat_a, 1);
    checkOutput("sat out_index", out_index_a, 0);

    // b: one chunk per neuron, activations 2.0, 5.0, 5.0
    applyStimulus(1, 1, 26'h0080000, 26'h0000000, 0);
    checkOutput("b n0 value", out_value_b, 32'h80000);
    checkOutput("b n0 index", out_index_b, 0);
    applyStimulus(1, 1, 26'h0140000, 26'h0000000, 0);
    checkOutput("b n1 index", out_index_b, 1);
    applyStimulus(1, 1, 26'h0140000, 26'h0000000, 0);
    checkOutput("b n2 valid", out_valid_b, 1);
    checkOutput("b n2 index", out_index_b, 2);
    checkOutput("b class early", class_valid_b, 0);
    // next image's chunk lands in the CLASSIFY cycle: 1.0 bias + 1.0
    applyStimulus(1, 1, 26'h0040000, 26'h0040000, 0);
    checkOutput("b class_valid", class_valid_b, 1);
    checkOutput("b class_id", class_id_b, 1);
    checkOutput("b class_score", class_score_b, 32'h140000);
    checkOutput("b next valid", out_valid_b, 1);
    checkOutput("b next index", out_index_b, 0);
    checkOutput("b next value", out_value_b, 32'h80000);
    applyStimulus(1, 0, '0, '0, 0);
    checkOutput("b class pulse end", class_valid_b, 0);

    // a, neuron 1 interrupted by reset after two chunks
    applyStimulus(0, 1, 26'h0040000, 26'h0040000, 0);
    applyStimulus(0, 1, 26'h0040000, 26'h0040000, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mid rst out_value_a", out_value_a, 0);
    checkOutput("mid rst out_sat_a", out_sat_a, 0);
    checkOutput("mid rst out_index_a", out_index_a, 0);
    checkOutput("mid rst class_id_b", class_id_b, 0);
    checkOutput("mid rst class_score_b", class_score_b, 0);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, 1, 26'h0010000, 26'h0010000, 0);
    applyStimulus(0, 1, 26'h0010000, 26'h0020000, 0);
    applyStimulus(0, 1, 26'h0010000, 26'h0020000, 0);
    checkOutput("post rst valid", out_valid_a, 1);
    checkOutput("post rst value", out_value_a, 32'h40000);
    checkOutput("post rst index", out_index_a, 0);

    // a, neuron 1: clr with a simultaneous chunk after two chunks
    applyStimulus(0, 1, 26'h0040000, 26'h0000000, 0);
    applyStimulus(0, 1, 26'h0040000, 26'h0000000, 0);
    applyStimulus(0, 1, 26'h0040000, 26'h0000000, 1);
    checkOutput("clr drop valid", out_valid_a, 0);
    applyStimulus(0, 1, 26'h0040000, 26'h0000000, 0);
    applyStimulus(0, 1, 26'h0040000, 26'h0000000, 0);
    checkOutput("clr restart early", out_valid_a, 0);
    applyStimulus(0, 1, 26'h0040000, 26'h0000000, 0);
    checkOutput("clr restart valid", out_valid_a, 1);
    checkOutput("clr restart index", out_index_a, 0);
    checkOutput("clr restart value", out_value_a, 32'hC0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
